// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe
//
// Pipelined barrel shifter / rotator. One register stage per shift-amount
// bit: stage k shifts by 2^k when amount bit k is set, otherwise it passes
// the word through. One result per cycle, latency SHW cycles.
//
// Handshake (both sides): a beat transfers on a rising clk edge where
// valid && ready. The producer holds valid and its payload stable until the
// transfer. out_valid never drops without a transfer. in_ready depends only
// on out_valid/out_ready, never on in_valid.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input handshake
//   in_data [WIDTH]     operand
//   in_amt  [SHW]       shift amount 0..WIDTH-1
//   in_mode [2]         00 LSL, 01 LSR, 10 ASR, 11 ROR
//   out_valid/out_ready output handshake
//   out_data [WIDTH]    result
//   out_zero            out_data == 0, qualified by out_valid
module barrel_shift_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    // Stage registers
    logic [SHW-1:0]   valid_q;
    logic [WIDTH-1:0] data_q [SHW];
    logic [1:0]       mode_q [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    logic             zero_q;

    // Per-stage inputs (stage 0 sees the ports) and shifted results
    logic [SHW-1:0]   src_valid;
    logic [WIDTH-1:0] src_data [SHW];
    logic [1:0]       src_mode [SHW];
    logic [SHW-1:0]   src_amt  [SHW];
    logic [WIDTH-1:0] nxt_data [SHW];

    logic adv;

    // One stage's shift by s. ASR sign-fills from the stage input's MSB;
    // since every stage does the same, the sign carries through the chain.
    function automatic logic [WIDTH-1:0] stage_op(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       mode,
                                                  input int               s);
        logic [WIDTH-1:0] r;
        case (mode)
            MODE_LSL: r = d << s;
            MODE_LSR: r = d >> s;
            MODE_ASR: r = $signed(d) >>> s;
            default:  r = (d >> s) | (d << (WIDTH - s));
        endcase
        return r;
    endfunction

    // Global stall: the whole pipe moves only when the output slot is free
    // or being drained this cycle.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_zero  = zero_q;

    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        src_mode[0]  = in_mode;
        src_amt[0]   = in_amt;
        for (int k = 1; k < SHW; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_amt[k]   = amt_q[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            nxt_data[k] = src_amt[k][k] ? stage_op(src_data[k], src_mode[k], 1 << k)
                                        : src_data[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            zero_q  <= 1'b0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                mode_q[k] <= '0;
                amt_q[k]  <= '0;
            end
        end else if (adv) begin
            // Stage 0 valid is in_valid && in_ready; in_ready == adv here.
            valid_q <= src_valid;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= nxt_data[k];
                mode_q[k] <= src_mode[k];
                amt_q[k]  <= src_amt[k];
            end
            // Zero flag is resolved alongside the final shift so out_zero
            // comes straight from a register.
            zero_q <= (nxt_data[SHW-1] == '0);
        end
    end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed bench for barrel_shift_pipe: an 8-bit instance driven through a
// scoreboard, and a 32-bit instance checked inline.
module tb_barrel_shift_pipe;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 8-bit DUT ----------------
  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_zero8;
  logic [7:0] in_data8, out_data8;
  logic [2:0] in_amt8;
  logic [1:0] in_mode8;

  barrel_shift_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_amt(in_amt8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .out_zero(out_zero8)
  );

  // ---------------- 32-bit DUT ----------------
  logic        in_valid32, in_ready32, out_valid32, out_ready32, out_zero32;
  logic [31:0] in_data32, out_data32;
  logic [4:0]  in_amt32;
  logic [1:0]  in_mode32;

  barrel_shift_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_amt(in_amt32), .in_mode(in_mode32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .out_data(out_data32), .out_zero(out_zero32)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard (8-bit) ----------------
  logic [8:0] exp_q[$];   // {zero, data}
  int         acc_q[$];   // acceptance cycle of each beat
  int         n_spurious = 0;
  bit         lat_chk = 1'b1;
  logic [8:0] mon_e;
  int         mon_a;

  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      if (exp_q.size() == 0) begin
        n_spurious++;
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = acc_q.pop_front();
        check("out_data8", {24'd0, out_data8}, {24'd0, mon_e[7:0]});
        check("out_zero8", {31'd0, out_zero8}, {31'd0, mon_e[8]});
        if (lat_chk) check("latency8", cyc - mon_a + 1, 3);
      end
    end
  end

  // ---------------- drivers ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send8(input logic [1:0] mode, input logic [7:0] data,
                       input logic [2:0] amt, input logic [7:0] exp_d);
    int n;
    n = 0;
    in_valid8 = 1'b1;
    in_mode8  = mode;
    in_data8  = data;
    in_amt8   = amt;
    @(negedge clk);
    while (!in_ready8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept8_in_time", {31'd0, n < 50}, 1);
    @(posedge clk); #1;
    exp_q.push_back({exp_d == 8'd0, exp_d});
    acc_q.push_back(cyc);
  endtask

  task automatic idle8();
    in_valid8 = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain8", exp_q.size(), 0);
  endtask

  task automatic run32(input logic [1:0] mode, input logic [31:0] data,
                       input logic [4:0] amt, input logic [31:0] exp_d);
    int n;
    in_valid32 = 1'b1;
    in_mode32  = mode;
    in_data32  = data;
    in_amt32   = amt;
    @(posedge clk); #1;   // pipe idle, in_ready32 is high
    in_valid32 = 1'b0;
    n = 1;
    while (!out_valid32 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency32", n, 5);
    check("out_data32", out_data32, exp_d);
    check("out_zero32", {31'd0, out_zero32}, {31'd0, exp_d == 32'd0});
  endtask

  logic [7:0] ror_exp [8] = '{8'h6A, 8'h35, 8'h9A, 8'h4D, 8'hA6, 8'h53, 8'hA9, 8'hD4};

  // ---------------- main sequence ----------------
  initial begin
    in_valid8 = 0; in_data8 = 0; in_amt8 = 0; in_mode8 = 0; out_ready8 = 1;
    in_valid32 = 0; in_data32 = 0; in_amt32 = 0; in_mode32 = 0; out_ready32 = 1;

    // Reset state
    #3;
    check("rst_out_valid8", {31'd0, out_valid8}, 0);
    check("rst_out_data8",  {24'd0, out_data8}, 0);
    check("rst_out_zero8",  {31'd0, out_zero8}, 0);
    check("rst_in_ready8",  {31'd0, in_ready8}, 1);
    check("rst_out_valid32", {31'd0, out_valid32}, 0);
    check("rst_in_ready32",  {31'd0, in_ready32}, 1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beats, one mode/amount at a time
    send8(LSL, 8'h6A, 3'd3, 8'h50); idle8(); wait_drain();
    send8(LSR, 8'h6A, 3'd1, 8'h35); idle8(); wait_drain();
    send8(ASR, 8'h96, 3'd2, 8'hE5); idle8(); wait_drain();
    send8(ASR, 8'h96, 3'd7, 8'hFF); idle8(); wait_drain();
    send8(ASR, 8'h6A, 3'd3, 8'h0D); idle8(); wait_drain();
    send8(LSR, 8'h96, 3'd7, 8'h01); idle8(); wait_drain();
    send8(ROR, 8'h6A, 3'd4, 8'hA6); idle8(); wait_drain();
    send8(ROR, 8'h6A, 3'd0, 8'h6A); idle8(); wait_drain();
    send8(LSL, 8'h80, 3'd1, 8'h00); idle8(); wait_drain();

    // Back-to-back ROR stream; constant latency implies consecutive outputs
    for (int i = 0; i < 8; i++) send8(ROR, 8'h6A, 3'(i), ror_exp[i]);
    idle8();
    wait_drain();

    // Backpressure: three beats in, then stall the output
    send8(LSL, 8'h01, 3'd1, 8'h02);
    send8(LSR, 8'hF0, 3'd4, 8'h0F);
    send8(ASR, 8'h80, 3'd3, 8'hF0);
    idle8();
    out_ready8 = 1'b0;
    lat_chk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready",  {31'd0, in_ready8}, 0);
      check("stall_out_valid", {31'd0, out_valid8}, 1);
      check("stall_out_data",  {24'd0, out_data8}, 32'h02);
      check("stall_out_zero",  {31'd0, out_zero8}, 0);
    end
    @(posedge clk); #1;
    out_ready8 = 1'b1;
    wait_drain();
    lat_chk = 1'b1;

    // Reset mid-stream with two beats in flight
    out_ready8 = 1'b0;
    lat_chk = 1'b0;
    send8(LSL, 8'h6A, 3'd3, 8'h50);
    send8(ROR, 8'h6A, 3'd1, 8'h35);
    idle8();
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_reset_valid", {31'd0, out_valid8}, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid8}, 0);
    check("async_rst_out_data",  {24'd0, out_data8}, 0);
    check("async_rst_out_zero",  {31'd0, out_zero8}, 0);
    check("async_rst_in_ready",  {31'd0, in_ready8}, 1);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready8 = 1'b1;
    lat_chk = 1'b1;
    @(posedge clk); #1;
    send8(ASR, 8'h96, 3'd2, 8'hE5);
    idle8();
    wait_drain();
    repeat (6) @(posedge clk);
    #1;

    // 32-bit instance
    run32(ASR, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF);
    run32(ROR, 32'h0000_0001, 5'd1,  32'h8000_0000);
    run32(LSL, 32'h0000_0001, 5'd31, 32'h8000_0000);
    run32(LSR, 32'h8000_0000, 5'd16, 32'h0000_8000);
    run32(LSL, 32'h0000_0002, 5'd31, 32'h0000_0000);

    check("spurious_beats8", n_spurious, 0);
    check("missing_beats8", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/barrel_shift_pipe.md
# barrel_shift_pipe

Parametrised, pipelined barrel shifter/rotator. Successor to the combinational 8:1 mux and barrel-shifter exercises. Each shift-amount bit is resolved in its own registered mux stage, giving one result per cycle at any WIDTH. A valid/ready handshake sits on both sides, so it drops into streaming datapaths with backpressure.

## Interface
Parameters:
- WIDTH, 8: data width; power of two, ≥ 2.
- SHW, $clog2(WIDTH): derived; width of shift amount and number of pipeline stages. Not to be overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset: asynchronous, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount, 0..WIDTH-1.
- in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  shifted/rotated result.
- out_zero  output  1  out_data == 0; qualified by out_valid.

## Operation
- Pipeline of SHW stages, k = 0..SHW-1.
- Stage k registers the following:
  - valid bit
  - data
  - mode
  - the remaining amount bits
- Stage k applies a shift by 2^k when amount bit k is set. Otherwise it passes the data unchanged.
- Per-stage operation by mode, with fill/wrap rules:
  - LSL: shift left, fill with 0.
  - LSR: shift right, fill with 0.
  - ASR: shift right, fill with data[WIDTH-1] as it stands at that stage's input. The sign is preserved through the stages, so the final result equals the single-step arithmetic shift.
  - ROR: rotate right; bits leaving the LSB re-enter at the MSB.
- Overall result is identical to a single combinational shift by in_amt in the given mode. Bits shifted out of the word are discarded (no carry output).
- Amount 0 passes in_data unchanged in all modes.
- out_data and out_zero are taken from the last stage's registers. out_zero is computed one stage earlier and registered with the data. No combinational path from in_* to out_*.
- Flow control is a global stall: `adv = !out_valid || out_ready`.
  - in_ready = adv (combinational from out_valid/out_ready only).
  - When adv = 1, every stage loads from its predecessor, and stage 0 loads from the inputs.
  - Stage 0 valid = in_valid && in_ready.
  - When adv = 0, every stage holds its contents.
- Bubbles (valid = 0 stages) propagate. They are not collapsed.
- Beats leave in acceptance order. No beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+SHW-1, i.e. SHW register stages (WIDTH=8: 3 cycles).
- Throughput: one beat per cycle while out_ready stays high.
- Output rules:
  - While out_valid = 1 and out_ready = 0, out_data, out_zero and out_valid are held stable.
  - out_valid does not deassert without a transfer.
- Reset (rst_n low, any time, including mid-stream):
  - Asynchronously clears all stage valid bits, data, mode and amount registers to 0.
  - out_valid = 0, out_data = 0, out_zero = 0.
  - in_ready = 1, since out_valid = 0.
  - In-flight beats are discarded.
- Reset release: the first accepting edge is the first rising clk edge with rst_n high.
- Simultaneous output transfer and input acceptance in the same cycle is normal operation.
- in_amt ≥ WIDTH cannot be represented, since SHW bits cover exactly 0..WIDTH-1.

## Test plan
- WIDTH=8, LSL, in_data=0x6A, in_amt=3 → out_data=0x50, out_zero=0, out_valid 3 cycles after acceptance.
- LSR 0x6A by 1 → 0x35; ASR 0x96 by 2 → 0xE5; ASR 0x96 by 7 → 0xFF; ROR 0x6A by 4 → 0xA6; ROR 0x6A by 0 → 0x6A.
- LSL 0x80 by 1 → 0x00 with out_zero=1.
- Back-to-back stream, with out_ready=1:
  - Input: one 0x6A beat per cycle for amt=0..7 in ROR.
  - Required output: 8 consecutive valid beats 0x6A, 0x35, 0x9A, 0x4D, 0xA6, 0x53, 0xA9, 0xD4, in order.
- Backpressure:
  - Stimulus: fill the pipe with 3 beats, then hold out_ready=0 for 5 cycles.
  - While stalled: in_ready=0, and out_data is held on the first result.
  - After out_ready=1: the remaining beats exit one per cycle, in order, with none lost.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 between clock edges with 2 beats in flight.
  - Required: out_valid, out_data and out_zero go to 0 immediately, without waiting for clk.
  - After release, the old beats never appear, and a new beat emerges with 3-cycle latency.
- WIDTH=32 instance:
  - ASR 0x80000001 by 31 → 0xFFFFFFFF.
  - ROR 0x00000001 by 1 → 0x80000000.
  - Latency is 5 cycles.
